// File: rtl/bcd_timer_7seg.sv
// rtl/bcd_timer_7seg.sv - multi-digit BCD up/down timer with common-anode 7-segment drive
module bcd_timer_7seg #(
  parameter int                  DIGITS      = 2,
  parameter logic [4*DIGITS-1:0] PRESET      = 8'h15,
  parameter bit                  AUTO_RELOAD = 1'b1,
  parameter bit                  BLANK_LZ    = 1'b0
) (
  input  logic                  ck,
  input  logic                  rs,
  input  logic                  en,
  input  logic                  up,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   ld_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [8*DIGITS-1:0]   seg,
  output logic                  tc,
  output logic                  done
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] ld_clamp;
  logic [W-1:0] ld_eff;
  logic [W-1:0] bcd_inc;
  logic [W-1:0] bcd_dec;
  logic         carry;
  logic         borrow;
  logic         at_term;
  logic         hi_zero;

  // Active-low {dp,g..a} pattern for one BCD digit; non-BCD codes go dark
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Clamp each load nibble to 9, then cap the whole value at the ceiling
  always_comb begin
    ld_clamp = '0;
    for (int i = 0; i < DIGITS; i++) begin
      ld_clamp[4*i +: 4] = (ld_val[4*i +: 4] > 4'd9) ? 4'd9 : ld_val[4*i +: 4];
    end
    ld_eff = (ld_clamp > PRESET) ? PRESET : ld_clamp;
  end

  // Ripple decimal increment and decrement of the current count
  always_comb begin
    bcd_inc = bcd;
    bcd_dec = bcd;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (bcd[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Terminal value depends on the direction presented this cycle
  always_comb begin
    at_term = up ? (bcd == PRESET) : (bcd == '0);
  end

  // Count register: load beats stepping; a finished one-shot ignores en
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      bcd  <= PRESET;
      tc   <= 1'b0;
      done <= 1'b0;
    end else if (ld) begin
      bcd  <= ld_eff;
      tc   <= 1'b0;
      done <= 1'b0;
    end else if (en && !done) begin
      if (at_term) begin
        tc <= 1'b1;
        if (AUTO_RELOAD) begin
          bcd <= up ? '0 : PRESET;
        end else begin
          done <= 1'b1;
        end
      end else begin
        tc  <= 1'b0;
        bcd <= up ? bcd_inc : bcd_dec;
      end
    end else begin
      tc <= 1'b0;
    end
  end

  // Decode every digit, walking down from the top to find leading zeros
  always_comb begin
    seg     = '0;
    hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero & (bcd[4*i +: 4] == 4'd0);
      if (BLANK_LZ && hi_zero && (i != 0)) begin
        seg[8*i +: 8] = 8'hFF;
      end else begin
        seg[8*i +: 8] = seg7(bcd[4*i +: 4]);
      end
    end
  end

endmodule

// File: tb/tb_bcd_timer_7seg.sv
// tb/tb_bcd_timer_7seg.sv - scoreboard bench for bcd_timer_7seg in three configurations
module tb_bcd_timer_7seg;

  logic        ck = 1'b0;
  logic        rs;
  logic        en0, up0, ld0, en1, up1, ld1, en2, up2, ld2;
  logic [7:0]  ldv0, ldv1;
  logic [11:0] ldv2;
  logic [7:0]  bcd0, bcd1;
  logic [11:0] bcd2;
  logic [15:0] seg0, seg1;
  logic [23:0] seg2;
  logic        tc0, tc1, tc2, done0, done1, done2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int idn   = 0;

  typedef struct {
    int          due;
    int          d;
    int          id;
    logic [11:0] b;
    logic        t;
    logic        dn;
  } exp_t;

  exp_t q[$];

  logic [7:0] dn_seq [0:16] = '{8'h14, 8'h13, 8'h12, 8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                                8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h15, 8'h14};
  logic [7:0] up_seq [0:15] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00};

  bcd_timer_7seg u0 (
    .ck(ck), .rs(rs), .en(en0), .up(up0), .ld(ld0), .ld_val(ldv0),
    .bcd(bcd0), .seg(seg0), .tc(tc0), .done(done0)
  );

  bcd_timer_7seg #(.AUTO_RELOAD(1'b0)) u1 (
    .ck(ck), .rs(rs), .en(en1), .up(up1), .ld(ld1), .ld_val(ldv1),
    .bcd(bcd1), .seg(seg1), .tc(tc1), .done(done1)
  );

  bcd_timer_7seg #(.DIGITS(3), .PRESET(12'h100), .BLANK_LZ(1'b1)) u2 (
    .ck(ck), .rs(rs), .en(en2), .up(up2), .ld(ld2), .ld_val(ldv2),
    .bcd(bcd2), .seg(seg2), .tc(tc2), .done(done2)
  );

  always #5 ck = ~ck;

  always @(posedge ck) cyc <= cyc + 1;

  function automatic logic [7:0] code(input logic [3:0] d);
    case (d)
      4'd0: code = 8'hC0;  4'd1: code = 8'hF9;  4'd2: code = 8'hA4;  4'd3: code = 8'hB0;
      4'd4: code = 8'h99;  4'd5: code = 8'h92;  4'd6: code = 8'h82;  4'd7: code = 8'hF8;
      4'd8: code = 8'h80;  4'd9: code = 8'h90;  default: code = 8'hFF;
    endcase
  endfunction

  function automatic logic [23:0] seg_model(input logic [11:0] v, input int nd, input bit blank);
    logic [23:0] r;
    bit          allz;
    logic [3:0]  dg;
    r    = '0;
    allz = 1'b1;
    for (int i = nd - 1; i >= 0; i--) begin
      dg   = v[4*i +: 4];
      allz = allz && (dg == 4'd0);
      r[8*i +: 8] = (blank && allz && i > 0) ? 8'hFF : code(dg);
    end
    return r;
  endfunction

  // now=1: check in the current cycle; otherwise after the next rising edge
  task automatic push(input int d, input logic [11:0] b, input logic t, input logic dn, input bit now = 1'b0);
    exp_t e;
    e.due = now ? cyc : cyc + 1;
    e.d   = d;
    e.id  = idn;
    e.b   = b;
    e.t   = t;
    e.dn  = dn;
    idn++;
    q.push_back(e);
  endtask

  task automatic nxt();
    @(negedge ck);
  endtask

  // Monitor: pops every expectation due this cycle and compares with the DUT
  initial begin
    exp_t        e;
    logic [11:0] ab;
    logic [23:0] as, es;
    logic        at, ad;
    forever begin
      @(negedge ck);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        case (e.d)
          0:       begin ab = {4'h0, bcd0}; as = {8'h00, seg0}; at = tc0; ad = done0;
                         es = seg_model(e.b, 2, 1'b0); end
          1:       begin ab = {4'h0, bcd1}; as = {8'h00, seg1}; at = tc1; ad = done1;
                         es = seg_model(e.b, 2, 1'b0); end
          default: begin ab = bcd2; as = seg2; at = tc2; ad = done2;
                         es = seg_model(e.b, 3, 1'b1); end
        endcase
        total++;
        if (ab !== e.b || as !== es || at !== e.t || ad !== e.dn) begin
          bad++;
          $display("FAIL dut%0d_chk%0d: got bcd=%h seg=%h tc=%b done=%b want bcd=%h seg=%h tc=%b done=%b",
                   e.d, e.id, ab, as, at, ad, e.b, es, e.t, e.dn);
        end
      end
    end
  end

  initial begin
    rs = 1'b0;
    {en0, up0, ld0, en1, up1, ld1, en2, up2, ld2} = '0;
    ldv0 = '0; ldv1 = '0; ldv2 = '0;
    nxt();
    push(0, 12'h015, 1'b0, 1'b0, 1'b1);
    push(1, 12'h015, 1'b0, 1'b0, 1'b1);
    push(2, 12'h100, 1'b0, 1'b0, 1'b1);
    nxt();

    // Default down count with auto-reload
    rs = 1'b1; en0 = 1'b1; up0 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push(0, {4'h0, dn_seq[i]}, (i == 15), 1'b0);
      nxt();
    end
    en0 = 1'b0;

    // One-shot down count, hold at 00, then reload via ld
    en1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(1, (i == 15) ? 12'h000 : {4'h0, dn_seq[i]}, (i == 15), (i == 15));
      nxt();
    end
    for (int i = 0; i < 5; i++) begin
      push(1, 12'h000, 1'b0, 1'b1);
      nxt();
    end
    ld1 = 1'b1; ldv1 = 8'h07;
    push(1, 12'h007, 1'b0, 1'b0); nxt();
    ld1 = 1'b0;
    push(1, 12'h006, 1'b0, 1'b0); nxt();
    push(1, 12'h005, 1'b0, 1'b0); nxt();
    en1 = 1'b0;

    // Up count through the decimal carry and the ceiling wrap
    ld0 = 1'b1; ldv0 = 8'h00; en0 = 1'b1;
    push(0, 12'h000, 1'b0, 1'b0); nxt();
    ld0 = 1'b0; up0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(0, {4'h0, up_seq[i]}, (i == 15), 1'b0);
      nxt();
    end
    push(0, 12'h001, 1'b0, 1'b0); nxt();
    up0 = 1'b0;
    push(0, 12'h000, 1'b0, 1'b0); nxt();
    push(0, 12'h015, 1'b1, 1'b0); nxt();
    en0 = 1'b0;

    // Load clamping, capping and load-over-enable
    ld0 = 1'b1;
    ldv0 = 8'h3C; push(0, 12'h015, 1'b0, 1'b0); nxt();
    ldv0 = 8'h05; push(0, 12'h005, 1'b0, 1'b0); nxt();
    ldv0 = 8'h1A; push(0, 12'h015, 1'b0, 1'b0); nxt();
    ldv0 = 8'h08; en0 = 1'b1; push(0, 12'h008, 1'b0, 1'b0); nxt();
    ldv0 = 8'h9F; en0 = 1'b0; push(0, 12'h015, 1'b0, 1'b0); nxt();
    ldv0 = 8'h08; push(0, 12'h008, 1'b0, 1'b0); nxt();
    ld0 = 1'b0; en0 = 1'b1;
    push(0, 12'h007, 1'b0, 1'b0); nxt();

    // Asynchronous reset in the middle of a cycle showing 07
    en0 = 1'b0;
    @(posedge ck);
    #2;
    rs = 1'b0;
    #1;
    push(0, 12'h015, 1'b0, 1'b0, 1'b1);
    push(1, 12'h015, 1'b0, 1'b0, 1'b1);
    push(2, 12'h100, 1'b0, 1'b0, 1'b1);
    nxt();
    rs = 1'b1; en0 = 1'b1;
    push(0, 12'h014, 1'b0, 1'b0); nxt();
    en0 = 1'b0;

    // Three digits with leading-zero blanking
    en2 = 1'b1; up2 = 1'b0;
    push(2, 12'h099, 1'b0, 1'b0); nxt();
    ld2 = 1'b1; ldv2 = 12'h006;
    push(2, 12'h006, 1'b0, 1'b0); nxt();
    ld2 = 1'b0;
    push(2, 12'h005, 1'b0, 1'b0); nxt();
    en2 = 1'b0; ld2 = 1'b1; ldv2 = 12'h0FA;
    push(2, 12'h099, 1'b0, 1'b0); nxt();
    ld2 = 1'b0; en2 = 1'b1; up2 = 1'b1;
    push(2, 12'h100, 1'b0, 1'b0); nxt();
    push(2, 12'h000, 1'b1, 1'b0); nxt();
    push(2, 12'h001, 1'b0, 1'b0); nxt();
    en2 = 1'b0;

    repeat (3) nxt();
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
